// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer: stalls fetch, drains the pipe, then pushes or pops PC and flags.
// Optional macro IRQ_LATCH_EN adds a pending latch so short irq pulses are not lost.
module interrupt_sequencer #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq_in,
    input  logic       rti_in,
    output logic       busy,
    output logic       stall_pc,
    output logic       mem_push,
    output logic       mem_pop,
    output logic [1:0] mem_write_src_sel,
    output logic       pc_choose_interrupt,
    output logic       pc_choose_memory,
    output logic       flag_restore_en,
    output logic       irq_ack
);

    typedef enum logic [3:0] {
        IDLE,
        I_DRAIN,
        I_PUSH_HI,
        I_PUSH_LO,
        I_PUSH_FL,
        I_VECTOR,
        R_DRAIN,
        R_POP_FL,
        R_POP_LO,
        R_POP_HI,
        R_RESUME
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             irq_req;

`ifdef IRQ_LATCH_EN
    logic pending;

    // Clear has priority: the source may still hold irq_in during the ack cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= 1'b0;
        else if (irq_ack)
            pending <= 1'b0;
        else if (irq_in)
            pending <= 1'b1;
    end

    assign irq_req = pending | irq_in;
`else
    assign irq_req = irq_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        cnt_nxt             = cnt;
        busy                = 1'b1;
        stall_pc            = 1'b0;
        mem_push            = 1'b0;
        mem_pop             = 1'b0;
        mem_write_src_sel   = 2'b00;
        pc_choose_interrupt = 1'b0;
        pc_choose_memory    = 1'b0;
        flag_restore_en     = 1'b0;
        irq_ack             = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                // RTI wins a tie; a level irq is still there when we come back.
                if (rti_in) begin
                    state_nxt = R_DRAIN;
                    cnt_nxt   = CNT_LOAD;
                end else if (irq_req) begin
                    state_nxt = I_DRAIN;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            I_DRAIN, R_DRAIN: begin
                stall_pc = 1'b1;
                if (cnt == '0)
                    state_nxt = (state == I_DRAIN) ? I_PUSH_HI : R_POP_FL;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            I_PUSH_HI: begin
                stall_pc          = 1'b1;
                mem_push          = 1'b1;
                mem_write_src_sel = 2'b00;
                state_nxt         = I_PUSH_LO;
            end
            I_PUSH_LO: begin
                stall_pc          = 1'b1;
                mem_push          = 1'b1;
                mem_write_src_sel = 2'b01;
                state_nxt         = I_PUSH_FL;
            end
            I_PUSH_FL: begin
                stall_pc          = 1'b1;
                mem_push          = 1'b1;
                mem_write_src_sel = 2'b10;
                state_nxt         = I_VECTOR;
            end
            I_VECTOR: begin
                pc_choose_interrupt = 1'b1;
                irq_ack             = 1'b1;
                state_nxt           = IDLE;
            end
            R_POP_FL: begin
                stall_pc        = 1'b1;
                mem_pop         = 1'b1;
                flag_restore_en = 1'b1;
                state_nxt       = R_POP_LO;
            end
            R_POP_LO: begin
                stall_pc  = 1'b1;
                mem_pop   = 1'b1;
                state_nxt = R_POP_HI;
            end
            R_POP_HI: begin
                stall_pc  = 1'b1;
                mem_pop   = 1'b1;
                state_nxt = R_RESUME;
            end
            R_RESUME: begin
                pc_choose_memory = 1'b1;
                state_nxt        = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: expected per-cycle output words are queued, then popped
// and compared at each falling edge. A second instance runs with DRAIN_CYCLES=1.
module tb_interrupt_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic irq_in = 1'b0, rti_in = 1'b0, irq1 = 1'b0;

    logic       busy, stall_pc, mem_push, mem_pop, pc_int, pc_mem, flag_rest, irq_ack;
    logic [1:0] sel;
    logic       busy1, stall1, push1, pop1, pc_int1, pc_mem1, flag1, ack1;
    logic [1:0] sel1;

    always #5 clk = ~clk;

    interrupt_sequencer #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .rti_in(rti_in),
        .busy(busy), .stall_pc(stall_pc), .mem_push(mem_push), .mem_pop(mem_pop),
        .mem_write_src_sel(sel), .pc_choose_interrupt(pc_int), .pc_choose_memory(pc_mem),
        .flag_restore_en(flag_rest), .irq_ack(irq_ack)
    );

    interrupt_sequencer #(.DRAIN_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .irq_in(irq1), .rti_in(1'b0),
        .busy(busy1), .stall_pc(stall1), .mem_push(push1), .mem_pop(pop1),
        .mem_write_src_sel(sel1), .pc_choose_interrupt(pc_int1), .pc_choose_memory(pc_mem1),
        .flag_restore_en(flag1), .irq_ack(ack1)
    );

    // {busy, stall, push, pop, sel[1:0], pc_int, pc_mem, flag_restore, ack}
    logic [9:0] obs, obs1;
    assign obs  = {busy, stall_pc, mem_push, mem_pop, sel, pc_int, pc_mem, flag_rest, irq_ack};
    assign obs1 = {busy1, stall1, push1, pop1, sel1, pc_int1, pc_mem1, flag1, ack1};

    localparam logic [9:0] E_IDLE  = 10'b00_0000_0000;
    localparam logic [9:0] E_DRAIN = 10'b11_0000_0000;
    localparam logic [9:0] E_PHI   = 10'b11_1000_0000;
    localparam logic [9:0] E_PLO   = 10'b11_1001_0000;
    localparam logic [9:0] E_PFL   = 10'b11_1010_0000;
    localparam logic [9:0] E_VEC   = 10'b10_0000_1001;
    localparam logic [9:0] E_POPFL = 10'b11_0100_0010;
    localparam logic [9:0] E_POP   = 10'b11_0100_0000;
    localparam logic [9:0] E_RES   = 10'b10_0000_0100;

    int n_chk = 0;
    int n_fail = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_v;

    task automatic push_irq_seq(input int d);
        for (int i = 0; i < d; i++) sb.push_back(E_DRAIN);
        sb.push_back(E_PHI);
        sb.push_back(E_PLO);
        sb.push_back(E_PFL);
        sb.push_back(E_VEC);
    endtask

    task automatic push_rti_seq(input int d);
        for (int i = 0; i < d; i++) sb.push_back(E_DRAIN);
        sb.push_back(E_POPFL);
        sb.push_back(E_POP);
        sb.push_back(E_POP);
        sb.push_back(E_RES);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(E_IDLE);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold got %b exp %b", obs, E_IDLE);
        end
        n_chk++;
        if (obs1 !== E_IDLE) begin
            n_fail++;
            $display("FAIL reset_hold_d1 got %b exp %b", obs1, E_IDLE);
        end
        reset = 1'b1;
        push_idle(3);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle got %b exp %b", obs, exp_v);
            end
        end
    endtask

    // Level irq held until ack; rti pulse mid-push must be dropped.
    task automatic test_irq_entry(input bit rti_mid);
        int k = 0;
        irq_in = 1'b1;
        push_irq_seq(3);
        push_idle(4);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL irq_entry rti_mid=%0d cyc %0d got %b exp %b", rti_mid, k, obs, exp_v);
            end
            rti_in = rti_mid && (k == 3);
            if (exp_v[0]) irq_in = 1'b0;
            k++;
        end
    endtask

    task automatic test_rti_return();
        int k = 0;
        rti_in = 1'b1;
        push_rti_seq(3);
        push_idle(3);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            rti_in = 1'b0;
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rti_return cyc %0d got %b exp %b", k, obs, exp_v);
            end
            k++;
        end
    endtask

    task automatic test_both();
        int k = 0;
        irq_in = 1'b1;
        rti_in = 1'b1;
        push_rti_seq(3);
        push_idle(1);
        push_irq_seq(3);
        push_idle(3);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            rti_in = 1'b0;
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL both cyc %0d got %b exp %b", k, obs, exp_v);
            end
            if (exp_v[0]) irq_in = 1'b0;
            k++;
        end
    endtask

    task automatic test_reset_abort();
        irq_in = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_chk++;
        if (obs !== E_PLO) begin
            n_fail++;
            $display("FAIL abort_at_push_lo got %b exp %b", obs, E_PLO);
        end
        #1 reset = 1'b0;
        #1;
        n_chk++;
        if (obs !== E_IDLE) begin
            n_fail++;
            $display("FAIL abort_async got %b exp %b", obs, E_IDLE);
        end
        irq_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_idle(6);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL abort_after got %b exp %b", obs, exp_v);
            end
        end
    endtask

    // Single-cycle irq pulse during R_DRAIN.
    task automatic test_irq_pulse();
        int k = 0;
        rti_in = 1'b1;
        push_rti_seq(3);
        push_idle(1);
`ifdef IRQ_LATCH_EN
        push_irq_seq(3);
        push_idle(3);
`else
        push_idle(10);
`endif
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            rti_in = 1'b0;
            irq_in = (k == 0);
            n_chk++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL irq_pulse cyc %0d got %b exp %b", k, obs, exp_v);
            end
            k++;
        end
        irq_in = 1'b0;
    endtask

    task automatic test_drain_one();
        int k = 0;
        irq1 = 1'b1;
        push_irq_seq(1);
        push_idle(5);
        while (sb.size() > 0) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            n_chk++;
            if (obs1 !== exp_v) begin
                n_fail++;
                $display("FAIL drain_one cyc %0d got %b exp %b", k, obs1, exp_v);
            end
            if (exp_v[0]) irq1 = 1'b0;
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_irq_entry(1'b0);
        test_rti_return();
        test_both();
        test_irq_entry(1'b1);
        test_reset_abort();
        test_irq_pulse();
        test_drain_one();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
